// File: rtl/add64_seq_pkg.sv
// Shared ALU definitions for the sequential 64-bit add/subtract unit:
// FSM state encoding, operation codes and datapath widths.
package add64_seq_pkg;

  localparam int DATA_W = 64;
  localparam int HALF_W = 32;
  localparam int CNT_W  = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/add64_seq_add32.sv
// Plain 32-bit ripple-style adder with carry in/out, reused by the
// sequential 64-bit unit for both halves of every operation.
module add64_seq_add32
  import add64_seq_pkg::*;
(
  input  logic              cin,
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  output logic [HALF_W-1:0] res,
  output logic              cout
);

  assign {cout, res} = {1'b0, a} + {1'b0, b} + {{HALF_W{1'b0}}, cin};

endmodule

// File: rtl/add64_seq.sv
// 64-bit add/subtract built from one 32-bit adder used twice per request
// (low half, then high half) behind a valid/ready handshake on both sides.
module add64_seq
  import add64_seq_pkg::*;
#(
  parameter bit SUB_EN = 1'b1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] res,
  output logic              cout,
  output logic              ovf,
  output logic              zero,
  output logic [CNT_W-1:0]  op_cnt
);

  state_t              r_state;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_op;
  logic [HALF_W-1:0]   r_resLo;
  logic                r_carryLo;
  logic [DATA_W-1:0]   r_res;
  logic                r_cout;
  logic                r_ovf;
  logic                r_zero;
  logic [CNT_W-1:0]    r_opCnt;

  logic [DATA_W-1:0]   w_bEff;
  logic                w_hiPass;
  logic [HALF_W-1:0]   w_addA;
  logic [HALF_W-1:0]   w_addB;
  logic                w_addCin;
  logic [HALF_W-1:0]   w_sum;
  logic                w_carry;

  // Subtraction is a + ~b + 1; the +1 enters as the low-pass carry-in.
  assign w_bEff   = r_op ? ~r_b : r_b;
  assign w_hiPass = (r_state == HI);
  assign w_addA   = w_hiPass ? r_a[DATA_W-1:HALF_W]    : r_a[HALF_W-1:0];
  assign w_addB   = w_hiPass ? w_bEff[DATA_W-1:HALF_W] : w_bEff[HALF_W-1:0];
  assign w_addCin = w_hiPass ? r_carryLo : r_op;

  add64_seq_add32 u_add32 (
    .cin  (w_addCin),
    .a    (w_addA),
    .b    (w_addB),
    .res  (w_sum),
    .cout (w_carry)
  );

  assign in_ready  = rst_n && (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign res       = r_res;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign op_cnt    = r_opCnt;

  // Low half lands in r_resLo so res keeps the previous result until HI completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= OP_ADD;
      r_resLo   <= '0;
      r_carryLo <= 1'b0;
      r_res     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_zero    <= 1'b0;
      r_opCnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= SUB_EN ? op : OP_ADD;
            r_state <= LO;
          end
        end
        LO: begin
          r_resLo   <= w_sum;
          r_carryLo <= w_carry;
          r_state   <= HI;
        end
        HI: begin
          r_res   <= {w_sum, r_resLo};
          r_cout  <= w_carry;
          r_ovf   <= (r_a[DATA_W-1] == w_bEff[DATA_W-1]) &&
                     (w_sum[HALF_W-1] != r_a[DATA_W-1]);
          r_zero  <= ({w_sum, r_resLo} == '0);
          r_state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_opCnt <= r_opCnt + 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add64_seq.sv
// Self-checking bench for add64_seq: table vectors, handshake corner cases,
// randomized operations against an arithmetic reference, and counter wrap.
module tb_add64_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        op;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_ready;

  logic        in_ready,  out_valid,  cout,  ovf,  zero;
  logic [63:0] res;
  logic [15:0] op_cnt;
  logic        in_ready0, out_valid0, cout0, ovf0, zero0;
  logic [63:0] res0;
  logic [15:0] op_cnt0;

  int nCompared;
  int nMismatched;
  int expCnt;

  typedef struct {
    logic [63:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
  } result_t;

  typedef struct {
    logic        op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic [63:0] res0;
  } vec_t;

  add64_seq #(.SUB_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .cout(cout), .ovf(ovf), .zero(zero), .op_cnt(op_cnt)
  );

  add64_seq #(.SUB_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .op(op), .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
    .res(res0), .cout(cout0), .ovf(ovf0), .zero(zero0), .op_cnt(op_cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #4000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: exact unsigned and signed arithmetic on wide integers.
  function automatic result_t refModel(input logic o, input logic [63:0] x, input logic [63:0] y);
    result_t            r;
    logic [64:0]        u;
    logic signed [65:0] s;
    logic signed [65:0] sx;
    logic signed [65:0] sy;
    sx = $signed({{2{x[63]}}, x});
    sy = $signed({{2{y[63]}}, y});
    if (o) begin
      u      = {1'b0, x} - {1'b0, y};
      r.cout = ~u[64];
      s      = sx - sy;
    end else begin
      u      = {1'b0, x} + {1'b0, y};
      r.cout = u[64];
      s      = sx + sy;
    end
    r.res  = u[63:0];
    r.ovf  = (s[65:63] != 3'b000) && (s[65:63] != 3'b111);
    r.zero = (u[63:0] == 64'd0);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One full request with out_ready high; returns what was seen in DONE.
  task automatic applyStimulus(input logic o, input logic [63:0] x, input logic [63:0] y,
                               output result_t r, output logic [63:0] r0, output int lat);
    int g;
    g = 0;
    while (!in_ready && g < 10) begin
      @(negedge clk);
      g++;
    end
    checkOutput("in_ready_wait", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = ~o;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    r.res  = res;
    r.cout = cout;
    r.ovf  = ovf;
    r.zero = zero;
    r0     = res0;
    @(negedge clk);
  endtask

  vec_t        vecs[10];
  result_t     got;
  result_t     exp;
  result_t     snap;
  logic [63:0] got0;
  int          lat;
  logic        ro;
  logic [63:0] rx;
  logic [63:0] ry;
  int          g;

  initial begin
    vecs[0] = '{1'b0, 64'h00000000_FFFFFFFF, 64'h1, 64'h00000001_00000000, 1'b0, 1'b0, 1'b0, 64'h00000001_00000000};
    vecs[1] = '{1'b1, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0, 1'b1, 64'd10};
    vecs[2] = '{1'b1, 64'd0, 64'd1, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0, 1'b0, 64'd1};
    vecs[3] = '{1'b0, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 64'h80000000_00000000, 1'b0, 1'b1, 1'b0, 64'h80000000_00000000};
    vecs[4] = '{1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFE, 1'b1, 1'b0, 1'b0, 64'hFFFFFFFF_FFFFFFFE};
    vecs[5] = '{1'b1, 64'd3, 64'd2, 64'd1, 1'b1, 1'b0, 1'b0, 64'd5};
    vecs[6] = '{1'b1, 64'h80000000_00000000, 64'h1, 64'h7FFFFFFF_FFFFFFFF, 1'b1, 1'b1, 1'b0, 64'h80000000_00000001};
    vecs[7] = '{1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 64'd0};
    vecs[8] = '{1'b1, 64'h00000001_00000000, 64'h1, 64'h00000000_FFFFFFFF, 1'b1, 1'b0, 1'b0, 64'h00000001_00000001};
    vecs[9] = '{1'b0, 64'h80000000_00000000, 64'h80000000_00000000, 64'd0, 1'b1, 1'b1, 1'b1, 64'd0};

    nCompared = 0;
    nMismatched = 0;
    expCnt = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    op = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_res", res, 64'd0);
    checkOutput("rst_flags", {61'd0, cout, ovf, zero}, 64'd0);
    checkOutput("rst_op_cnt", {48'd0, op_cnt}, 64'd0);
    checkOutput("rst_dut0", {46'd0, in_ready0, out_valid0, op_cnt0}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rel_in_ready0", {63'd0, in_ready0}, 64'd1);

    // Reset lands while the request is in its high pass.
    in_valid = 1'b1;
    op = 1'b0;
    a = 64'h11;
    b = 64'h22;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("hi_out_valid", {63'd0, out_valid}, 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rsthi_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("rsthi_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rsthi_res", res, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rsthi_idle", {63'd0, in_ready}, 64'd1);
      checkOutput("rsthi_no_result", {63'd0, out_valid}, 64'd0);
      checkOutput("rsthi_op_cnt", {48'd0, op_cnt}, 64'd0);
    end

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, got, got0, lat);
      expCnt++;
      checkOutput($sformatf("vec%0d_latency", i), lat, 64'd3);
      checkOutput($sformatf("vec%0d_res", i), got.res, vecs[i].res);
      checkOutput($sformatf("vec%0d_cout", i), {63'd0, got.cout}, {63'd0, vecs[i].cout});
      checkOutput($sformatf("vec%0d_ovf", i), {63'd0, got.ovf}, {63'd0, vecs[i].ovf});
      checkOutput($sformatf("vec%0d_zero", i), {63'd0, got.zero}, {63'd0, vecs[i].zero});
      checkOutput($sformatf("vec%0d_res_nosub", i), got0, vecs[i].res0);
      checkOutput($sformatf("vec%0d_op_cnt", i), {48'd0, op_cnt}, expCnt);
      checkOutput($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, 64'd0);
    end

    // Consumer stalls in DONE while a second request is offered.
    out_ready = 1'b0;
    exp = refModel(1'b1, 64'h00000000_00001234, 64'h00000000_00005678);
    in_valid = 1'b1;
    op = 1'b1;
    a = 64'h00000000_00001234;
    b = 64'h00000000_00005678;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!out_valid && g < 10);
    checkOutput("stall_latency", g, 64'd3);
    snap.res = res;
    snap.cout = cout;
    snap.ovf = ovf;
    snap.zero = zero;
    checkOutput("stall_res", snap.res, exp.res);
    checkOutput("stall_flags", {61'd0, snap.cout, snap.ovf, snap.zero}, {61'd0, exp.cout, exp.ovf, exp.zero});
    in_valid = 1'b1;
    op = 1'b0;
    a = 64'hDEAD_BEEF_0000_0001;
    b = 64'h0BAD_F00D_0000_0002;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_hold_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("stall_hold_res", res, exp.res);
      checkOutput("stall_hold_flags", {61'd0, cout, ovf, zero}, {61'd0, exp.cout, exp.ovf, exp.zero});
      checkOutput("stall_in_ready", {63'd0, in_ready}, 64'd0);
      checkOutput("stall_op_cnt", {48'd0, op_cnt}, expCnt);
    end
    out_ready = 1'b1;
    @(negedge clk);
    expCnt++;
    checkOutput("handoff_op_cnt", {48'd0, op_cnt}, expCnt);
    checkOutput("handoff_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("handoff_out_valid", {63'd0, out_valid}, 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("no_accept_on_handoff", {63'd0, in_ready}, 64'd1);
    checkOutput("res_kept_idle", res, exp.res);

    for (int i = 0; i < 200; i++) begin
      ro = 1'($urandom_range(0, 1));
      rx = {$urandom, $urandom};
      ry = ($urandom_range(0, 3) == 0) ? rx : {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) ry = {32'd0, $urandom};
      exp = refModel(ro, rx, ry);
      applyStimulus(ro, rx, ry, got, got0, lat);
      expCnt++;
      checkOutput($sformatf("rnd%0d_latency", i), lat, 64'd3);
      checkOutput($sformatf("rnd%0d_res", i), got.res, exp.res);
      checkOutput($sformatf("rnd%0d_flags", i), {61'd0, got.cout, got.ovf, got.zero}, {61'd0, exp.cout, exp.ovf, exp.zero});
      checkOutput($sformatf("rnd%0d_res_nosub", i), got0, refModel(1'b0, rx, ry).res);
      checkOutput($sformatf("rnd%0d_op_cnt", i), {48'd0, op_cnt}, 64'(expCnt & 16'hFFFF));
    end

    // Back-to-back stream long enough to wrap the completion counter.
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("wrap_start_cnt", {48'd0, op_cnt}, 64'd0);
    rx = {$urandom, $urandom};
    ry = {$urandom, $urandom};
    exp = refModel(1'b0, rx, ry);
    in_valid = 1'b1;
    op = 1'b0;
    a = rx;
    b = ry;
    out_ready = 1'b1;
    repeat (4 * 65535) @(negedge clk);
    checkOutput("wrap_cnt_ffff", {48'd0, op_cnt}, 64'hFFFF);
    repeat (4) @(negedge clk);
    checkOutput("wrap_cnt_0000", {48'd0, op_cnt}, 64'h0000);
    checkOutput("wrap_cnt0_0000", {48'd0, op_cnt0}, 64'h0000);
    checkOutput("wrap_last_res", res, exp.res);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
